mobius_seq: RTL and testbench



---
 rtl/mobius_seq.sv | 116 +++++++++++
 tb/tb_mobius_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mobius_seq.sv
// Iterative GF(2) Moebius transform: one butterfly stage per clock over an N-bit working register.
// Latency: out_valid rises LOG2_N cycles after the acceptance edge; one vector per LOG2_N+2 cycles at best.
// Backpressure: in_ready low while RUN/DONE (no buffering); DONE holds out_data until out_ready.
module mobius_seq #(
    parameter int N      = 128,
    parameter int LOG2_N = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [0:N-1]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [0:N-1]  out_data,
    output logic          busy,
    output logic [7:0]    stage_cnt
);

    // Refuse to build a transform whose width is not a power of two matching the stage count.
    if (N != 2**LOG2_N || LOG2_N < 1) begin : g_param_check
        $error("mobius_seq: N must equal 2**LOG2_N with LOG2_N >= 1");
    end

    localparam int       IW         = LOG2_N;
    localparam logic [7:0] STAGE_LAST = 8'(LOG2_N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [0:N-1]    r_work;
    logic [7:0]      r_stage;

    state_t          w_state_nxt;
    logic [0:N-1]    w_work_nxt;
    logic [7:0]      w_stage_nxt;
    logic [0:N-1]    w_stage_out;
    logic [IW-1:0]   w_half;
    logic [IW-1:0]   w_idx;

    // Partner distance of the current stage; stage 0 pairs across the top index bit.
    assign w_half = IW'(1) << (LOG2_N - 1 - int'(r_stage));

    // Single butterfly stage: indices with the stage bit set absorb their partner below.
    always_comb begin
        w_stage_out = r_work;
        w_idx       = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = IW'(i);
            if ((w_idx & w_half) != '0) begin
                w_stage_out[i] = r_work[i] ^ r_work[w_idx ^ w_half];
            end
        end
    end

    // Next-state, datapath next values and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_stage_nxt = r_stage;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_work_nxt  = in_data;
                    w_stage_nxt = 8'd0;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy       = 1'b1;
                w_work_nxt = w_stage_out;
                if (r_stage == STAGE_LAST) begin
                    w_stage_nxt = 8'd0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_stage_nxt = r_stage + 8'd1;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and working register; reset discards any in-flight vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_stage <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_stage <= w_stage_nxt;
        end
    end

    assign out_data  = r_work;
    assign stage_cnt = r_stage;

endmodule

// File: tb/tb_mobius_seq.sv
// Bench for mobius_seq: an N=8 instance for hand-computed vectors and a default N=128 instance.
// Stimulus pushes expected results into per-instance queues; negedge monitors pop and compare.
// Also checks latency, stage_cnt sequencing, backpressure hold, mid-RUN reset and back-to-back spacing.
module tb_mobius_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // N=8 instance
    logic        rst8, in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [0:7]  in_data8, out_data8;
    logic [7:0]  stage_cnt8;

    // N=128 instance
    logic        rst128, in_valid128, in_ready128, out_valid128, out_ready128, busy128;
    logic [0:127] in_data128, out_data128;
    logic [7:0]  stage_cnt128;

    mobius_seq #(.N(8), .LOG2_N(3)) u_dut8 (
        .clk(clk), .rst(rst8),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .busy(busy8), .stage_cnt(stage_cnt8)
    );

    mobius_seq u_dut128 (
        .clk(clk), .rst(rst128),
        .in_valid(in_valid128), .in_ready(in_ready128), .in_data(in_data128),
        .out_valid(out_valid128), .out_ready(out_ready128), .out_data(out_data128),
        .busy(busy128), .stage_cnt(stage_cnt128)
    );

    logic [0:7]   exp8[$];
    logic [0:127] exp128[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Reference: out[i] = XOR of in[j] for every j whose set bits are a subset of i's.
    function automatic logic [0:127] mob_model(input logic [0:127] v);
        logic [0:127] r;
        r = '0;
        for (int i = 0; i < 128; i++)
            for (int j = 0; j < 128; j++)
                if (v[j] && ((j & ~i) == 0)) r[i] = ~r[i];
        return r;
    endfunction

    // ---------------- monitors ----------------
    int acc8 = 0;
    bit pov8 = 1'b0;
    always @(negedge clk) begin
        if (mon_en && !rst8) begin
            if (in_valid8 && in_ready8) acc8 = cyc + 1;
            if (out_valid8 && !pov8) chk("lat8", 128'(cyc - acc8), 128'(3));
            if (busy8 && !out_valid8) chk("stage8", 128'(stage_cnt8), 128'(cyc - acc8));
            else chk("stage8_idle", 128'(stage_cnt8), 128'(0));
            if (out_valid8 && out_ready8) begin
                if (exp8.size() == 0) fail_now("unexpected8");
                else chk("data8", 128'(out_data8), 128'(exp8.pop_front()));
            end
        end
        pov8 = out_valid8;
    end

    int acc128 = 0;
    bit pov128 = 1'b0;
    bit b2b = 1'b0;
    bit have_prev = 1'b0;
    always @(negedge clk) begin
        if (mon_en && !rst128) begin
            if (in_valid128 && in_ready128) begin
                if (b2b && have_prev) chk("spacing", 128'(cyc + 1 - acc128), 128'(9));
                acc128 = cyc + 1;
                have_prev = b2b;
            end
            if (out_valid128 && !pov128) chk("lat128", 128'(cyc - acc128), 128'(7));
            if (busy128 && !out_valid128) chk("stage128", 128'(stage_cnt128), 128'(cyc - acc128));
            else chk("stage128_idle", 128'(stage_cnt128), 128'(0));
            if (out_valid128 && out_ready128) begin
                if (exp128.size() == 0) fail_now("unexpected128");
                else chk("data128", out_data128, exp128.pop_front());
            end
        end
        pov128 = out_valid128;
    end

    // ---------------- stimulus helpers (called at #1 after a posedge) ----------------
    task automatic accept8(input logic [0:7] x);
        int t = 0;
        while (!in_ready8 && t < 50) begin @(posedge clk); #1; t++; end
        if (!in_ready8) fail_now("timeout_in_ready8");
        in_data8 = x; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic send8(input logic [0:7] x, input logic [0:7] y);
        exp8.push_back(y);
        accept8(x);
    endtask

    task automatic wait_idle8();
        int t = 0;
        while (!(exp8.size() == 0 && in_ready8) && t < 100) begin @(posedge clk); #1; t++; end
        if (!(exp8.size() == 0 && in_ready8)) fail_now("timeout_idle8");
    endtask

    task automatic send128(input logic [0:127] x, input logic [0:127] y);
        int t = 0;
        exp128.push_back(y);
        while (!in_ready128 && t < 50) begin @(posedge clk); #1; t++; end
        if (!in_ready128) fail_now("timeout_in_ready128");
        in_data128 = x; in_valid128 = 1'b1;
        @(posedge clk); #1;
        in_valid128 = 1'b0;
    endtask

    task automatic wait_idle128();
        int t = 0;
        while (!(exp128.size() == 0 && in_ready128) && t < 100) begin @(posedge clk); #1; t++; end
        if (!(exp128.size() == 0 && in_ready128)) fail_now("timeout_idle128");
    endtask

    // Directed N=8 vectors with hand-derived transforms.
    logic [0:7] vin8 [6] = '{8'h80, 8'hFF, 8'h01, 8'h00, 8'hC0, 8'h40};
    logic [0:7] vout8[6] = '{8'hFF, 8'h80, 8'h01, 8'h00, 8'hAA, 8'h55};

    logic [0:127] x128, y128;

    initial begin
        rst8 = 1'b1; rst128 = 1'b1;
        in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b1;
        in_valid128 = 1'b0; in_data128 = '0; out_ready128 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst8 = 1'b0; rst128 = 1'b0;

        chk("rst_in_ready8", 128'(in_ready8), 128'(1));
        chk("rst_out_valid8", 128'(out_valid8), 128'(0));
        chk("rst_busy8", 128'(busy8), 128'(0));
        chk("rst_stage8", 128'(stage_cnt8), 128'(0));
        chk("rst_data8", 128'(out_data8), 128'(0));
        chk("rst_in_ready128", 128'(in_ready128), 128'(1));
        chk("rst_out_valid128", 128'(out_valid128), 128'(0));
        chk("rst_busy128", 128'(busy128), 128'(0));
        chk("rst_data128", out_data128, 128'(0));
        mon_en = 1'b1;

        // Directed vectors
        for (int k = 0; k < 6; k++) begin
            send8(vin8[k], vout8[k]);
            wait_idle8();
        end

        // Backpressure with in_valid noise during RUN and DONE
        out_ready8 = 1'b0;
        send8(8'h80, 8'hFF);
        in_valid8 = 1'b1; in_data8 = 8'h01;
        begin
            int t = 0;
            while (!out_valid8 && t < 20) begin @(posedge clk); #1; t++; end
            if (!out_valid8) fail_now("timeout_valid8");
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            in_data8 = 8'(k * 37);
            chk("bp_valid", 128'(out_valid8), 128'(1));
            chk("bp_data", 128'(out_data8), 128'(8'hFF));
            chk("bp_in_ready", 128'(in_ready8), 128'(0));
            chk("bp_busy", 128'(busy8), 128'(1));
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        wait_idle8();

        // Reset after stage 1 of 3
        accept8(8'hFF);
        @(posedge clk); @(posedge clk); #1;
        rst8 = 1'b1;
        @(posedge clk); #1;
        rst8 = 1'b0;
        chk("mrst_in_ready", 128'(in_ready8), 128'(1));
        chk("mrst_out_valid", 128'(out_valid8), 128'(0));
        chk("mrst_stage", 128'(stage_cnt8), 128'(0));
        chk("mrst_busy", 128'(busy8), 128'(0));
        chk("mrst_data", 128'(out_data8), 128'(0));
        send8(8'h80, 8'hFF);
        wait_idle8();

        // N=128: single index-0 bit spreads to all ones, and back
        x128 = '0; x128[0] = 1'b1;
        send128(x128, '1);
        wait_idle128();
        send128('1, x128);
        wait_idle128();

        // N=128 random vectors and involution round-trip
        for (int k = 0; k < 1000; k++) begin
            x128 = {$urandom(), $urandom(), $urandom(), $urandom()};
            y128 = mob_model(x128);
            send128(x128, y128);
            wait_idle128();
            send128(y128, x128);
            wait_idle128();
        end

        // Back-to-back with in_valid and out_ready held high
        x128 = {$urandom(), $urandom(), $urandom(), $urandom()};
        y128 = mob_model(x128);
        for (int k = 0; k < 4; k++) exp128.push_back(y128);
        have_prev = 1'b0;
        b2b = 1'b1;
        in_data128 = x128;
        in_valid128 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int t = 0;
            while (!in_ready128 && t < 50) begin @(posedge clk); #1; t++; end
            if (!in_ready128) fail_now("timeout_b2b");
            @(posedge clk); #1;
        end
        in_valid128 = 1'b0;
        wait_idle128();
        b2b = 1'b0;

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

endmodule
